rdma_meta_tx_arbiter: RTL

- Round-robin arbiter that merges per-region RDMA TX meta request streams (one per user region) into the single meta stream feeding the RDMA request path.
- Tags each forwarded request with the source region's vfid.
- Enforces a per-region burst quota so one region cannot monopolise the RDMA request path.
- Output is fully registered: 1-cycle latency, 1 request/cycle sustained throughput.

---
 rtl/rdma_meta_tx_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rdma_meta_tx_arbiter.sv
// Round-robin merge of per-region RDMA TX meta streams into one registered stream,
// tagging each request with its source vfid and capping bursts per region.
module rdma_meta_tx_arbiter #(
    parameter int N_REGIONS = 4,
    parameter int DATA_BITS = 32,
    parameter int MAX_BURST = 4,
    parameter int VFID_BITS = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [N_REGIONS-1:0]           s_meta_valid,
    output logic [N_REGIONS-1:0]           s_meta_ready,
    input  logic [N_REGIONS*DATA_BITS-1:0] s_meta_data,
    output logic                           m_meta_valid,
    input  logic                           m_meta_ready,
    output logic [DATA_BITS-1:0]           m_meta_data,
    output logic [VFID_BITS-1:0]           m_vfid,
    output logic                           busy
);

    localparam int CNT_BITS = $clog2(MAX_BURST + 1);

    logic                 r_valid;
    logic [DATA_BITS-1:0] r_data;
    logic [VFID_BITS-1:0] r_vfid;
    logic [VFID_BITS-1:0] r_last_grant;
    logic [CNT_BITS-1:0]  r_burst_cnt;

    logic                 w_load_en;
    logic                 w_any_valid;
    logic                 w_xfer;
    logic                 w_last_valid;
    logic                 w_sticky;
    logic                 w_found;
    logic [VFID_BITS-1:0] w_rr_grant;
    logic [VFID_BITS-1:0] w_grant;
    logic [DATA_BITS-1:0] w_sel_data;
    logic [CNT_BITS-1:0]  w_next_cnt;

    assign w_load_en   = !r_valid || m_meta_ready;
    assign w_any_valid = |s_meta_valid;
    assign w_xfer      = w_load_en && w_any_valid;

    // Grant selection: sticky on the current burst owner, else round-robin after it.
    always_comb begin
        w_last_valid = 1'b0;
        w_rr_grant   = r_last_grant;
        w_found      = 1'b0;
        for (int j = 0; j < N_REGIONS; j++) begin
            if (r_last_grant == VFID_BITS'(j)) begin
                w_last_valid = s_meta_valid[j];
            end else begin
                w_last_valid = w_last_valid;
            end
        end
        for (int k = 1; k <= N_REGIONS; k++) begin
            for (int j = 0; j < N_REGIONS; j++) begin
                if (!w_found && s_meta_valid[j] && (j == (int'(r_last_grant) + k) % N_REGIONS)) begin
                    w_rr_grant = VFID_BITS'(j);
                    w_found    = 1'b1;
                end else begin
                    w_found    = w_found;
                end
            end
        end
        // burst_cnt==0 means no burst has started yet, so reset hands region 0 first turn.
        w_sticky = w_last_valid && (r_burst_cnt != CNT_BITS'(0)) &&
                   (r_burst_cnt < CNT_BITS'(MAX_BURST));
        if (w_sticky) begin
            w_grant = r_last_grant;
        end else begin
            w_grant = w_rr_grant;
        end
    end

    // Payload mux and per-port accept for the granted region.
    always_comb begin
        w_sel_data   = {DATA_BITS{1'b0}};
        s_meta_ready = {N_REGIONS{1'b0}};
        for (int j = 0; j < N_REGIONS; j++) begin
            if (w_grant == VFID_BITS'(j)) begin
                w_sel_data      = s_meta_data[j*DATA_BITS +: DATA_BITS];
                s_meta_ready[j] = aresetn && w_xfer;
            end else begin
                s_meta_ready[j] = 1'b0;
            end
        end
        if ((w_grant == r_last_grant) && (r_burst_cnt < CNT_BITS'(MAX_BURST))) begin
            w_next_cnt = r_burst_cnt + CNT_BITS'(1);
        end else begin
            w_next_cnt = CNT_BITS'(1);
        end
    end

    // Output register slice plus arbitration history.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_valid      <= 1'b0;
            r_data       <= {DATA_BITS{1'b0}};
            r_vfid       <= {VFID_BITS{1'b0}};
            r_last_grant <= VFID_BITS'(N_REGIONS - 1);
            r_burst_cnt  <= CNT_BITS'(0);
        end else if (w_load_en) begin
            if (w_any_valid) begin
                r_valid      <= 1'b1;
                r_data       <= w_sel_data;
                r_vfid       <= w_grant;
                r_last_grant <= w_grant;
                r_burst_cnt  <= w_next_cnt;
            end else begin
                r_valid      <= 1'b0;
            end
        end else begin
            r_valid <= r_valid;
        end
    end

    assign m_meta_valid = r_valid;
    assign m_meta_data  = r_data;
    assign m_vfid       = r_vfid;
    assign busy         = r_valid || w_any_valid;

endmodule
